// File: rtl/instruction_fetch_memory.sv
// Instruction store with an internal program counter, a registered fetch path,
// stall, branch redirect and a program-load write port.
module instruction_fetch_memory #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] BranchTarget,
  input  logic                  LoadEnable,
  input  logic [ADDR_WIDTH-1:0] LoadAddress,
  input  logic [DATA_WIDTH-1:0] LoadData,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic [ADDR_WIDTH-1:0] InstructionAddress,
  output logic                  InstructionValid
);

  localparam int unsigned mem_depth = 2 ** ADDR_WIDTH;

  typedef logic [mem_depth-1:0][DATA_WIDTH-1:0] mem_t;

  // Power-up image: every word holds its own address, truncated to the word width.
  function automatic mem_t init_mem();
    mem_t m;
    for (int unsigned i = 0; i < mem_depth; i++) begin
      m[ADDR_WIDTH'(i)] = DATA_WIDTH'(i);
    end
    return m;
  endfunction

  mem_t mem_q = init_mem();

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;

  // Memory is only ever changed by the load port; reset leaves contents intact.
  always_ff @(posedge Clock) begin
    if (LoadEnable && !Reset) begin
      mem_q[LoadAddress] <= LoadData;
    end
  end

  // Load beats branch beats stall beats a normal fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (LoadEnable) begin
      valid_d = 1'b0;
    end else if (BranchTaken) begin
      pc_d    = BranchTarget;
      valid_d = 1'b0;
    end else if (!Stall) begin
      instr_d = mem_q[pc_q];
      addr_d  = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign Instruction        = instr_q;
  assign InstructionAddress = addr_q;
  assign InstructionValid   = valid_q;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Scoreboard bench for instruction_fetch_memory: directed stimulus pushes the
// expected fetched words, per-instance monitors pop and compare on every valid output.
module tb_instruction_fetch_memory;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Default instance: DATA_WIDTH=8, ADDR_WIDTH=4, RESET_PC=0
  logic       Reset = 1'b1, Stall = 1'b0, BranchTaken = 1'b0, LoadEnable = 1'b0;
  logic [3:0] BranchTarget = '0, LoadAddress = '0;
  logic [7:0] LoadData = '0;
  logic [7:0] Instruction;
  logic [3:0] InstructionAddress;
  logic       InstructionValid;

  instruction_fetch_memory dut_a (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .LoadEnable(LoadEnable), .LoadAddress(LoadAddress),
    .LoadData(LoadData), .Instruction(Instruction),
    .InstructionAddress(InstructionAddress), .InstructionValid(InstructionValid)
  );

  // Re-parametrised instance: DATA_WIDTH=16, ADDR_WIDTH=2, RESET_PC=3
  logic        b_reset = 1'b1, b_branch = 1'b0;
  logic [1:0]  b_target = '0;
  logic [15:0] b_instr;
  logic [1:0]  b_addr;
  logic        b_valid;

  instruction_fetch_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .RESET_PC(2'd3)) dut_b (
    .Clock(Clock), .Reset(b_reset), .Stall(1'b0), .BranchTaken(b_branch),
    .BranchTarget(b_target), .LoadEnable(1'b0), .LoadAddress(2'd0),
    .LoadData(16'h0000), .Instruction(b_instr),
    .InstructionAddress(b_addr), .InstructionValid(b_valid)
  );

  logic [11:0] qa[$];  // {data, addr}
  logic [17:0] qb[$];

  task automatic push_a(input logic [7:0] d, input logic [3:0] a);
    qa.push_back({d, a});
  endtask

  task automatic push_b(input logic [15:0] d, input logic [1:0] a);
    qb.push_back({d, a});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge.
  task automatic cyc(input logic rst, input logic st, input logic br, input logic [3:0] tgt,
                     input logic le, input logic [3:0] la, input logic [7:0] ld);
    @(negedge Clock);
    Reset = rst; Stall = st; BranchTaken = br; BranchTarget = tgt;
    LoadEnable = le; LoadAddress = la; LoadData = ld;
  endtask

  task automatic run();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic after_edge();
    @(posedge Clock);
    #2;
  endtask

  task automatic chk_reset_a(input string name);
    after_edge();
    chk({name, "_instr"}, 32'(Instruction), 32'h0);
    chk({name, "_addr"}, 32'(InstructionAddress), 32'h0);
    chk({name, "_valid"}, 32'(InstructionValid), 32'h0);
  endtask

  // Monitors: every valid output must match the head of its queue.
  always @(posedge Clock) begin
    #1;
    if (InstructionValid) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected: got data 0x%0h addr 0x%0h expected none", Instruction, InstructionAddress);
      end else begin
        logic [11:0] e;
        e = qa.pop_front();
        if ({Instruction, InstructionAddress} !== e) begin
          bad++;
          $display("FAIL a_fetch: got data 0x%0h addr 0x%0h expected data 0x%0h addr 0x%0h",
                   Instruction, InstructionAddress, e[11:4], e[3:0]);
        end
      end
    end
    if (b_valid) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected: got data 0x%0h addr 0x%0h expected none", b_instr, b_addr);
      end else begin
        logic [17:0] e;
        e = qb.pop_front();
        if ({b_instr, b_addr} !== e) begin
          bad++;
          $display("FAIL b_fetch: got data 0x%0h addr 0x%0h expected data 0x%0h addr 0x%0h",
                   b_instr, b_addr, e[17:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Wide-word, 4-deep instance; dut_a is held in reset meanwhile.
    @(negedge Clock);
    after_edge();
    chk("b_reset_valid", 32'(b_valid), 32'h0);
    chk("b_reset_instr", 32'(b_instr), 32'h0);
    @(negedge Clock); b_reset = 1'b0;
    push_b(16'h0003, 2'd3);
    @(negedge Clock); push_b(16'h0000, 2'd0);
    @(negedge Clock); push_b(16'h0001, 2'd1);
    @(negedge Clock); b_branch = 1'b1;  // park it: continuous bubbles

    // Reset two cycles
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
    chk_reset_a("a_reset0");
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
    chk_reset_a("a_reset1");

    // Free run through the whole memory and wrap
    for (int i = 0; i < 18; i++) begin
      run();
      push_a(8'(i % 16), 4'(i % 16));
    end
    run(); push_a(8'h02, 4'h2);
    run(); push_a(8'h03, 4'h3);

    // Stall holds 0x03 valid for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
      push_a(8'h03, 4'h3);
    end
    run(); push_a(8'h04, 4'h4);
    run(); push_a(8'h05, 4'h5);

    // Branch to 0xA: one bubble then sequential fetch
    cyc(1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 8'h00);
    run(); push_a(8'h0A, 4'hA);
    run(); push_a(8'h0B, 4'hB);

    // Branch with stall still redirects; stall after keeps the bubble
    cyc(1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
    run(); push_a(8'h01, 4'h1);
    run(); push_a(8'h02, 4'h2);

    // Branch to the current PC: bubble then refetch
    cyc(1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 8'h00);
    run(); push_a(8'h03, 4'h3);

    // Load while running: bubble, PC holds, data/addr hold
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 8'hC5);
    after_edge();
    chk("a_load_valid", 32'(InstructionValid), 32'h0);
    chk("a_load_instr_hold", 32'(Instruction), 32'h03);
    chk("a_load_addr_hold", 32'(InstructionAddress), 32'h3);
    run(); push_a(8'h04, 4'h4);

    // Load beats simultaneous branch and stall
    cyc(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'h9, 8'h5A);
    run(); push_a(8'h05, 4'h5);

    // Loaded words are fetched back
    cyc(1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 8'h00);
    run(); push_a(8'hC5, 4'h2);
    run(); push_a(8'h03, 4'h3);
    cyc(1'b0, 1'b0, 1'b1, 4'h9, 1'b0, 4'h0, 8'h00);
    run(); push_a(8'h5A, 4'h9);
    run(); push_a(8'h0A, 4'hA);

    // Reset together with load and stall: load is dropped, memory survives reset
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h7, 8'hEE);
    chk_reset_a("a_reset_mid");
    run(); push_a(8'h00, 4'h0);
    run(); push_a(8'h01, 4'h1);
    run(); push_a(8'hC5, 4'h2);
    for (int i = 3; i < 8; i++) begin
      run();
      push_a(8'(i), 4'(i));
    end

    // Park in continuous bubbles and drain
    cyc(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    repeat (3) @(negedge Clock);
    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
